// File: rtl/led_pio_sequencer.sv
// LED pattern sequencer: an Avalon-MM config slave sets the pattern, period and mode,
// and an Avalon-MM write master pushes each new pattern to an 8-bit LED PIO.
module led_pio_sequencer #(
  parameter int          PERIOD_W       = 26,
  parameter int unsigned DEFAULT_PERIOD = 25000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, CLEAR} state_e;

  state_e              state_q, state_d;
  logic                en_q;
  logic [1:0]          mode_q;
  logic [PERIOD_W-1:0] period_q;
  logic [7:0]          pattern_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [7:0]          cur_q, cur_d;
  logic                dir_q, dir_d;

  logic                wr_en;
  logic [PERIOD_W:0]   cnt_inc;
  logic                step_due;
  logic [7:0]          nxt_cur;
  logic                nxt_dir;
  logic                running;

  assign wr_en   = s_chipselect && !s_write_n;
  assign running = (state_q != IDLE);

  // Config registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= 1'b0;
      mode_q    <= 2'b00;
      period_q  <= PERIOD_W'(DEFAULT_PERIOD);
      pattern_q <= 8'h00;
    end else if (wr_en) begin
      case (s_address)
        2'd0: begin
          en_q   <= s_writedata[0];
          mode_q <= s_writedata[2:1];
        end
        2'd1: period_q  <= s_writedata[PERIOD_W-1:0];
        2'd2: pattern_q <= s_writedata[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      2'd0: s_readdata[2:0]          = {mode_q, en_q};
      2'd1: s_readdata[PERIOD_W-1:0] = period_q;
      2'd2: s_readdata[7:0]          = pattern_q;
      default: s_readdata[8:0]       = {running, cur_q};
    endcase
  end

  // One extra bit keeps cnt+1 from wrapping; PERIOD=0 then steps every RUN cycle,
  // exactly as PERIOD=1 would.
  assign cnt_inc  = {1'b0, cnt_q} + {{PERIOD_W{1'b0}}, 1'b1};
  assign step_due = (cnt_inc >= {1'b0, period_q});

  always_comb begin
    nxt_cur = cur_q;
    nxt_dir = dir_q;
    case (mode_q)
      2'b01: nxt_cur = {cur_q[6:0], cur_q[7]};
      2'b10: begin
        if (!dir_q) begin
          if (cur_q[7]) begin
            nxt_dir = 1'b1;
            nxt_cur = cur_q >> 1;
          end else begin
            nxt_cur = cur_q << 1;
          end
        end else begin
          if (cur_q[0]) begin
            nxt_dir = 1'b0;
            nxt_cur = cur_q << 1;
          end else begin
            nxt_cur = cur_q >> 1;
          end
        end
      end
      2'b11: nxt_cur = ~cur_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= 8'h00;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    dir_d        = dir_q;
    m_address    = 2'b00;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = 32'h0;
    case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = LOAD;
          cur_d   = pattern_q;
          dir_d   = 1'b0;
        end
      end
      LOAD, STEP: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        m_writedata  = {24'h0, cur_q};
        cnt_d        = '0;
        state_d      = RUN;
      end
      RUN: begin
        if (!en_q) begin
          state_d = CLEAR;
        end else if (step_due) begin
          state_d = STEP;
          cur_d   = nxt_cur;
          dir_d   = nxt_dir;
        end else begin
          cnt_d = cnt_inc[PERIOD_W-1:0];
        end
      end
      CLEAR: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/led_pio_sequencer.md
LED_PIO_SEQUENCER -- requirements
Module: led_pio_sequencer

Interface
REQ-001 SHALL have parameter PERIOD_W, default 26, width of period register and step counter.
REQ-002 SHALL have parameter DEFAULT_PERIOD, default 25000000, reset value of PERIOD (0.5 s at 50 MHz).
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s_address in 2, s_chipselect in 1, s_write_n in 1, s_writedata in 32: Avalon-MM config slave, zero wait states.
REQ-006 SHALL have port s_readdata  out  32  combinational read mux of s_address.
REQ-007 SHALL have ports m_address out 2, m_chipselect out 1, m_write_n out 1, m_writedata out 32: Avalon-MM write master driving the 8-bit LED PIO s1 port.

Function
REQ-008 SHALL decode slave registers: 0 CTRL {mode[2:1], en[0]}; 1 PERIOD[PERIOD_W-1:0]; 2 PATTERN[7:0]; 3 STATUS read-only {running[8], cur[7:0]}; writes to 3 ignored.
REQ-009 SHALL capture a slave write when s_chipselect=1 and s_write_n=0; unused high bits read 0.
REQ-010 SHALL implement FSM states IDLE, LOAD, RUN, STEP, CLEAR.
REQ-011 IDLE: en=1 -> LOAD, cur<=PATTERN, dir<=0; else stay.
REQ-012 LOAD and STEP SHALL each last one cycle, clear counter, -> RUN.
REQ-013 RUN: en=0 -> CLEAR (priority over step); else if cnt+1 >= PERIOD -> STEP, cur<=next(cur); else cnt<=cnt+1.
REQ-014 CLEAR SHALL last one cycle, -> IDLE.
REQ-015 Step compare SHALL use PERIOD_W+1-bit arithmetic (no wrap); PERIOD=0 behaves as PERIOD=1.
REQ-016 Writes to PIO SHALL therefore occur every max(PERIOD,1)+1 cycles while running.
REQ-017 Master outputs SHALL be Moore-decoded: in LOAD/STEP chipselect=1, write_n=0, writedata={24'b0,cur}; in CLEAR chipselect=1, write_n=0, writedata=0; else chipselect=0, write_n=1, writedata=0; m_address always 0.
REQ-018 next(cur) by mode: 00 static cur; 01 rotate left {cur[6:0],cur[7]}; 10 bounce; 11 ~cur.
REQ-019 Bounce: dir=0 -> if cur[7] then dir<=1, cur>>1 else cur<<1; dir=1 -> if cur[0] then dir<=0, cur<<1 else cur>>1; zero pattern stays 0.
REQ-020 PATTERN writes while running SHALL NOT affect cur until next LOAD.
REQ-021 MODE/PERIOD writes SHALL take effect at the next RUN evaluation; a reduced PERIOD with cnt already past it steps on the next RUN cycle.
REQ-022 en cleared during LOAD/STEP SHALL let that write complete, then RUN -> CLEAR.
REQ-023 en set again during CLEAR SHALL restart via IDLE -> LOAD.
REQ-024 running SHALL be 1 whenever state != IDLE.

Reset
REQ-025 reset_n=0 SHALL asynchronously force IDLE, en=0, mode=0, PERIOD=DEFAULT_PERIOD, PATTERN=0, cur=0, dir=0, cnt=0, m_chipselect=0, m_write_n=1, m_writedata=0.
REQ-026 Reset mid-sequence SHALL abort without a CLEAR write; next write occurs only after LOAD.

Verification
REQ-027 PERIOD=3, PATTERN=0x01, CTRL=0x3 (rotate, en) -> writes 0x01 (LOAD) then 0x02, 0x04, ... 0x80, 0x01, spaced 4 cycles, m_address=0.
REQ-028 PERIOD=0, PATTERN=0x81, mode 10 -> writes every 2 cycles: 0x81, dir flips, 0x40, 0x20 ... 0x01, then 0x02.
REQ-029 mode 11, PATTERN=0xA5, PERIOD=2 -> alternating 0xA5, 0x5A every 3 cycles; STATUS reads {1,cur}.
REQ-030 CTRL en<=0 in RUN -> one write of 0x00 next cycle, then IDLE, STATUS=0x000 | cur, running=0; en<=0 during STEP -> STEP write completes first.
REQ-031 Write PATTERN=0xFF mid-run -> sequence unchanged; after disable/enable first write is 0xFF.
REQ-032 Assert reset_n low during STEP -> master outputs idle immediately; registers read back reset values, PERIOD=DEFAULT_PERIOD.
